// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter sharing the single-port data memory
module dmem_arbiter #(
  parameter int DMEM_WORDS = 1024,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_addr,
  input  logic        p0_we,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_addr,
  input  logic        p1_we,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [30:0] WORD_LIMIT = 31'(DMEM_WORDS);

  state_t      state_q;
  logic        ptr_q;
  logic        owner_q;
  logic        we_q;
  logic        oor_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [3:0]  mem_wstrb_q;
  logic [29:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  rsp_valid_q;
  logic        rsp_err_q;
  logic        rsp_read_q;

  logic        can_accept;
  logic        prefer1;
  logic        pick0;
  logic        pick1;
  logic        acc0;
  logic        acc1;
  logic        acc;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_oor;
  logic        unused_addr_lsbs;

  // Byte offset bits never select a word.
  assign unused_addr_lsbs = ^{p0_addr[1:0], p1_addr[1:0]};

  // Arbitration: a lone requester wins; on a tie the pointer (or fixed port 0) decides.
  always_comb begin
    can_accept = reset && (state_q != ST_CMD);
    prefer1    = (FIXED_PRIO == 0) && ptr_q;
    pick0      = p0_valid && (!p1_valid || !prefer1);
    pick1      = p1_valid && !pick0;
    acc0       = can_accept && pick0;
    acc1       = can_accept && pick1;
    acc        = acc0 || acc1;
    sel_addr   = acc1 ? p1_addr  : p0_addr;
    sel_we     = acc1 ? p1_we    : p0_we;
    sel_wdata  = acc1 ? p1_wdata : p0_wdata;
    sel_wstrb  = acc1 ? p1_wstrb : p0_wstrb;
    sel_oor    = ({1'b0, sel_addr[31:2]} >= WORD_LIMIT);
  end

  assign p0_ready = acc0;
  assign p1_ready = acc1;

  // Controller: latch the winning command, run one memory cycle, then pulse the response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= 4'b0;
      mem_addr_q  <= 30'b0;
      mem_wdata_q <= 32'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          rsp_valid_q <= 2'b00;
          rsp_err_q   <= 1'b0;
          rsp_read_q  <= 1'b0;
          if (acc) begin
            state_q     <= ST_CMD;
            owner_q     <= acc1;
            ptr_q       <= acc0;
            we_q        <= sel_we;
            oor_q       <= sel_oor;
            mem_en_q    <= !sel_oor;
            mem_we_q    <= sel_we && !sel_oor;
            mem_wstrb_q <= (sel_we && !sel_oor) ? sel_wstrb : 4'b0;
            mem_addr_q  <= sel_addr[31:2];
            mem_wdata_q <= sel_wdata;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CMD: begin
          state_q     <= ST_RESP;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_wstrb_q <= 4'b0;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          rsp_err_q   <= oor_q;
          rsp_read_q  <= !we_q && !oor_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes are forced low while reset is held, even before the reset edge lands.
  assign mem_en    = reset && mem_en_q;
  assign mem_we    = reset && mem_we_q;
  assign mem_wstrb = reset ? mem_wstrb_q : 4'b0;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Read data passes straight through from the synchronous memory during the response cycle.
  assign p0_rsp_valid = reset && rsp_valid_q[0];
  assign p1_rsp_valid = reset && rsp_valid_q[1];
  assign p0_rsp_err   = p0_rsp_valid && rsp_err_q;
  assign p1_rsp_err   = p1_rsp_valid && rsp_err_q;
  assign p0_rsp_rdata = (p0_rsp_valid && rsp_read_q) ? mem_rdata : 32'h0;
  assign p1_rsp_rdata = (p1_rsp_valid && rsp_read_q) ? mem_rdata : 32'h0;

endmodule
